// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment encodings, blank pattern and decoder FSM state type
// Patterns are packed {A,B,C,D,E,F,G} with segment A as bit 6.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_LOCKED  = 2'd2
    } seg_state_e;

    // Encoder-side helper: nibble to segment pattern.
    function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'h0:    pat = SEG_0;
            4'h1:    pat = SEG_1;
            4'h2:    pat = SEG_2;
            4'h3:    pat = SEG_3;
            4'h4:    pat = SEG_4;
            4'h5:    pat = SEG_5;
            4'h6:    pat = SEG_6;
            4'h7:    pat = SEG_7;
            4'h8:    pat = SEG_8;
            4'h9:    pat = SEG_9;
            4'hA:    pat = SEG_A;
            4'hB:    pat = SEG_B;
            4'hC:    pat = SEG_C;
            4'hD:    pat = SEG_D;
            4'hE:    pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_lookup.sv
// rtl/seg7_lookup.sv - combinational seven-segment pattern to nibble decoder
// Ports:
//   pattern_i [6:0]  segment pattern {A..G}
//   hit_o            pattern is one of the 16 table entries
//   nibble_o [3:0]   decoded digit, 0 when hit_o is low
module seg7_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       hit_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        hit_o    = 1'b1;
        nibble_o = 4'h0;
        case (pattern_i)
            SEG_0:   nibble_o = 4'h0;
            SEG_1:   nibble_o = 4'h1;
            SEG_2:   nibble_o = 4'h2;
            SEG_3:   nibble_o = 4'h3;
            SEG_4:   nibble_o = 4'h4;
            SEG_5:   nibble_o = 4'h5;
            SEG_6:   nibble_o = 4'h6;
            SEG_7:   nibble_o = 4'h7;
            SEG_8:   nibble_o = 4'h8;
            SEG_9:   nibble_o = 4'h9;
            SEG_A:   nibble_o = 4'hA;
            SEG_B:   nibble_o = 4'hB;
            SEG_C:   nibble_o = 4'hC;
            SEG_D:   nibble_o = 4'hD;
            SEG_E:   nibble_o = 4'hE;
            SEG_F:   nibble_o = 4'hF;
            default: hit_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/segment_to_binary.sv
// rtl/segment_to_binary.sv - debounced seven-segment pattern to binary digit decoder
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   seg_A_i .. seg_G_i    segment lines, active-high
//   binary_num_o [3:0]    last accepted digit
//   valid_o               one-cycle pulse on acceptance of a legal pattern
//   error_o               one-cycle pulse on acceptance of an illegal non-blank pattern
//   blank_o               level, high while the accepted pattern is blank
module segment_to_binary
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       seg_A_i,
    input  logic       seg_B_i,
    input  logic       seg_C_i,
    input  logic       seg_D_i,
    input  logic       seg_E_i,
    input  logic       seg_F_i,
    input  logic       seg_G_i,
    output logic [3:0] binary_num_o,
    output logic       valid_o,
    output logic       error_o,
    output logic       blank_o
);

    localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [6:0]       seg_vec;
    logic [6:0]       sample_q, sample_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    seg_state_e       state_q, state_d;
    logic             accepted_q, accepted_d;
    logic [6:0]       last_q, last_d;
    logic [3:0]       num_q, num_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             blank_q, blank_d;

    logic             seg_change;
    logic             stable;
    logic             is_new;
    logic             accept;
    logic             is_blank;
    logic             lut_hit;
    logic [3:0]       lut_nibble;

    assign seg_vec = {seg_A_i, seg_B_i, seg_C_i, seg_D_i, seg_E_i, seg_F_i, seg_G_i};

    // The value about to be registered into sample_q differs from the current one.
    assign seg_change = (seg_vec != sample_q);
    assign sample_d   = seg_vec;

    always_comb begin
        cnt_d = cnt_q;
        if (seg_change) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign stable   = (cnt_q == CNT_MAX);
    assign is_new   = !accepted_q || (sample_q != last_q);
    // LOCKED gate stops a held pattern from firing again while the counter sits saturated.
    assign accept   = stable && is_new && (state_q != ST_LOCKED);
    assign is_blank = (sample_q == SEG_BLANK);

    seg7_lookup u_lookup (
        .pattern_i (sample_q),
        .hit_o     (lut_hit),
        .nibble_o  (lut_nibble)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a sample change always wins over locking.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH: begin
                if (seg_change) begin
                    state_d = ST_QUALIFY;
                end else if (stable) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_QUALIFY: begin
                if (!seg_change && stable) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (seg_change) begin
                    state_d = ST_QUALIFY;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Output logic
    always_comb begin
        valid_d    = 1'b0;
        error_d    = 1'b0;
        num_d      = num_q;
        blank_d    = blank_q;
        accepted_d = accepted_q;
        last_d     = last_q;
        if (accept) begin
            accepted_d = 1'b1;
            last_d     = sample_q;
            blank_d    = is_blank;
            if (lut_hit) begin
                valid_d = 1'b1;
                num_d   = lut_nibble;
            end else if (!is_blank) begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sample_q   <= SEG_BLANK;
            cnt_q      <= '0;
            accepted_q <= 1'b0;
            last_q     <= SEG_BLANK;
            num_q      <= 4'h0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            blank_q    <= 1'b0;
        end else begin
            sample_q   <= sample_d;
            cnt_q      <= cnt_d;
            accepted_q <= accepted_d;
            last_q     <= last_d;
            num_q      <= num_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            blank_q    <= blank_d;
        end
    end

    assign binary_num_o = num_q;
    assign valid_o      = valid_q;
    assign error_o      = error_q;
    assign blank_o      = blank_q;

endmodule
